// File: rtl/bus_master.sv
// bus_master: single-word initiator for the CS_/WR_ register bus with programmable setup/strobe/hold.
// Optional bus_rdy wait-state extension with timeout is compiled in by defining BUS_MASTER_WAIT_EN.
`timescale 1ns/1ps

module bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       CS_,
    output logic       WR_,
    output logic [7:0] Addr,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
`ifdef BUS_MASTER_WAIT_EN
    input  logic       bus_rdy,
`endif
    input  logic [7:0] bus_din
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_wr;
    logic       r_tmo;
`ifdef BUS_MASTER_WAIT_EN
    logic [7:0] r_ext;
`endif

    logic       w_strobe_end;
    logic       w_timeout;
    logic [7:0] w_rd_val;

    // Decide when STROBE finishes and what value a read returns.
    always_comb begin
        w_strobe_end = 1'b0;
        w_timeout    = 1'b0;
        w_rd_val     = bus_din;
`ifdef BUS_MASTER_WAIT_EN
        // Once the programmed strobe length is used up, wait for bus_rdy or 255 extension cycles.
        if (r_cnt == 8'd0) begin
            w_strobe_end = bus_rdy | (r_ext == 8'hFF);
            w_timeout    = ~bus_rdy & (r_ext == 8'hFF);
        end else begin
            w_strobe_end = 1'b0;
            w_timeout    = 1'b0;
        end
        if (w_timeout) begin
            w_rd_val = 8'hFF;
        end else begin
            w_rd_val = bus_din;
        end
`else
        w_strobe_end = (r_cnt == 8'd0);
`endif
    end

    // Bus-cycle sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_wr     <= 1'b0;
            r_tmo    <= 1'b0;
`ifdef BUS_MASTER_WAIT_EN
            r_ext    <= 8'd0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'd0;
            err      <= 1'b0;
            CS_      <= 1'b1;
            WR_      <= 1'b1;
            Addr     <= 8'd0;
            bus_dout <= 8'd0;
            bus_oe   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done   <= 1'b0;
                    err    <= 1'b0;
                    CS_    <= 1'b1;
                    WR_    <= 1'b1;
                    bus_oe <= 1'b0;
                    if (req) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= SETUP_LD;
                        r_wr    <= req_wr;
                        r_tmo   <= 1'b0;
`ifdef BUS_MASTER_WAIT_EN
                        r_ext   <= 8'd0;
`endif
                        busy    <= 1'b1;
                        Addr    <= req_addr;
                        WR_     <= ~req_wr;
                        bus_oe  <= req_wr;
                        if (req_wr) begin
                            bus_dout <= req_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_STROBE;
                        r_cnt   <= STROBE_LD;
                        CS_     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (w_strobe_end) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= HOLD_LD;
                        r_tmo   <= w_timeout;
                        CS_     <= 1'b1;
                        if (!r_wr) begin
                            rdata <= w_rd_val;
                        end
                    end else if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
`ifdef BUS_MASTER_WAIT_EN
                        r_ext <= r_ext + 8'd1;
`endif
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= r_tmo;
                        WR_     <= 1'b1;
                        bus_oe  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    CS_     <= 1'b1;
                    WR_     <= 1'b1;
                    bus_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: two bus_master instances (default and S=2/T=3/H=2) driven by shared random stimulus
// and compared every cycle against a timeline model of each bus cycle.
`timescale 1ns/1ps

module tb_bus_master;

    localparam int S0 = 1, T0 = 2, H0 = 1;
    localparam int S1 = 2, T1 = 3, H1 = 2;
    localparam int NCYC = 3000;

    logic       clk = 1'b0;
    logic       rst, req, req_wr, rdy;
    logic [7:0] req_addr, req_wdata, bus_din;

    logic [1:0]      o_busy, o_done, o_err, o_cs, o_wr, o_oe;
    logic [1:0][7:0] o_rdata, o_addr, o_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_master #(.SETUP_CYC(S0), .STROBE_CYC(T0), .HOLD_CYC(H0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(o_busy[0]), .done(o_done[0]), .rdata(o_rdata[0]), .err(o_err[0]),
        .CS_(o_cs[0]), .WR_(o_wr[0]), .Addr(o_addr[0]), .bus_dout(o_dout[0]), .bus_oe(o_oe[0]),
`ifdef BUS_MASTER_WAIT_EN
        .bus_rdy(rdy),
`endif
        .bus_din(bus_din)
    );

    bus_master #(.SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(o_busy[1]), .done(o_done[1]), .rdata(o_rdata[1]), .err(o_err[1]),
        .CS_(o_cs[1]), .WR_(o_wr[1]), .Addr(o_addr[1]), .bus_dout(o_dout[1]), .bus_oe(o_oe[1]),
`ifdef BUS_MASTER_WAIT_EN
        .bus_rdy(rdy),
`endif
        .bus_din(bus_din)
    );

    // Model: m_t counts cycles since the accept edge; strobe ends after cycle m_send.
    bit         m_act  [2];
    int         m_t    [2];
    int         m_send [2];
    logic       m_wr   [2];
    logic       m_tmo  [2];
    logic [7:0] e_addr [2];
    logic [7:0] e_dout [2];
    logic [7:0] e_rdata[2];
    logic       e_done [2];
    logic       e_err  [2];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int s_of(input int i); return (i == 0) ? S0 : S1; endfunction
    function automatic int t_of(input int i); return (i == 0) ? T0 : T1; endfunction
    function automatic int h_of(input int i); return (i == 0) ? H0 : H1; endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 1'b0; m_t[i] = 0; m_send[i] = 0; m_wr[i] = 1'b0; m_tmo[i] = 1'b0;
                e_addr[i] = 8'h00; e_dout[i] = 8'h00; e_rdata[i] = 8'h00;
                e_done[i] = 1'b0; e_err[i] = 1'b0;
            end else begin
                e_done[i] = 1'b0;
                e_err[i]  = 1'b0;
                if (m_act[i]) begin
                    if (m_t[i] == m_send[i]) begin
                        if (rdy || (m_t[i] - (s_of(i) + t_of(i))) == 255) begin
                            m_tmo[i] = !rdy;
                            if (!m_wr[i]) e_rdata[i] = m_tmo[i] ? 8'hFF : bus_din;
                        end else begin
                            m_send[i] = m_send[i] + 1;
                        end
                    end
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] == m_send[i] + h_of(i) + 1) begin
                        m_act[i]  = 1'b0;
                        e_done[i] = 1'b1;
                        e_err[i]  = m_tmo[i];
                    end
                end else if (req) begin
                    m_act[i]  = 1'b1;
                    m_t[i]    = 1;
                    m_send[i] = s_of(i) + t_of(i);
                    m_wr[i]   = req_wr;
                    m_tmo[i]  = 1'b0;
                    e_addr[i] = req_addr;
                    if (req_wr) e_dout[i] = req_wdata;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_cs, exp_wr, exp_oe;
        for (int i = 0; i < 2; i++) begin
            exp_cs = !(m_act[i] && m_t[i] > s_of(i) && m_t[i] <= m_send[i]);
            exp_wr = m_act[i] ? !m_wr[i] : 1'b1;
            exp_oe = m_act[i] && m_wr[i];
            check_eq($sformatf("u%0d.busy", i), {7'd0, o_busy[i]}, {7'd0, m_act[i]});
            check_eq($sformatf("u%0d.done", i), {7'd0, o_done[i]}, {7'd0, e_done[i]});
            check_eq($sformatf("u%0d.err", i), {7'd0, o_err[i]}, {7'd0, e_err[i]});
            check_eq($sformatf("u%0d.CS_", i), {7'd0, o_cs[i]}, {7'd0, exp_cs});
            check_eq($sformatf("u%0d.WR_", i), {7'd0, o_wr[i]}, {7'd0, exp_wr});
            check_eq($sformatf("u%0d.bus_oe", i), {7'd0, o_oe[i]}, {7'd0, exp_oe});
            check_eq($sformatf("u%0d.Addr", i), o_addr[i], e_addr[i]);
            check_eq($sformatf("u%0d.bus_dout", i), o_dout[i], e_dout[i]);
            check_eq($sformatf("u%0d.rdata", i), o_rdata[i], e_rdata[i]);
        end
    endtask

    task automatic drive(input int cyc);
        bus_din = 8'($urandom);
        rdy     = 1'b1;
`ifdef BUS_MASTER_WAIT_EN
        if (cyc >= 300 && cyc < 900) rdy = 1'b0;
        else if (cyc >= 900) rdy = ($urandom_range(0, 3) != 0);
`endif
        if (cyc < 2) begin
            rst = 1'b1; req = 1'b0;
        end else if (cyc < 12) begin
            rst = 1'b0; req = 1'b0;
        end else if (cyc == 12) begin
            req = 1'b1; req_wr = 1'b1; req_addr = 8'hF0; req_wdata = 8'h5A;
        end else if (cyc < 20) begin
            req = 1'b0;
        end else if (cyc < 45) begin
            req = 1'b1; req_wr = (cyc < 24); req_addr = (cyc < 24) ? 8'h0F : 8'hF0; req_wdata = 8'hC3;
        end else if (cyc < 60) begin
            req = (cyc == 50); req_wr = 1'b0; req_addr = 8'hA2;
        end else if (cyc == 60) begin
            req = 1'b1; req_wr = 1'b0; req_addr = 8'h77;
        end else if (cyc == 65) begin
            rst = 1'b1; req = 1'b0;
        end else if (cyc < 70) begin
            rst = 1'b0; req = 1'b0;
        end else begin
            rst       = ($urandom_range(0, 149) == 0);
            req       = ($urandom_range(0, 2) != 0);
            req_wr    = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req_wr = 1'b0; rdy = 1'b1;
        req_addr = 8'h00; req_wdata = 8'h00; bus_din = 8'h00;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_edge();
            #1;
            drive(cyc);
            @(negedge clk);
            check_outputs();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
